// File: rtl/sdram_burst_streamer_if.sv
// ============================================================================
// Module      : sdram_burst_streamer_if
// Description : Bus bundle between the burst streamer (master side) and the
//               SDRAM controller, scan-out requester and per-channel FIFOs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sdram_burst_streamer_if #(
  parameter int NUM_CH = 2,
  parameter int CH_W   = 3
);
  logic              i_SDRAM_Requested;
  logic              o_SDRAM_Yield;
  logic [1:0]        o_Command;
  logic [21:0]       o_Data_Address;
  logic              i_Data_Read_Valid;
  logic              i_Data_Write_Done;
  logic [NUM_CH-1:0] i_Rd_Ready;
  logic [NUM_CH-1:0] o_Rd_Wrreq;
  logic [NUM_CH-1:0] i_Wr_Ready;
  logic [NUM_CH-1:0] o_Wr_Rdreq;
  logic [CH_W-1:0]   o_Wr_Sel;
  logic              i_Restart;
  logic [NUM_CH-1:0] o_Wrap;

  // Streamer side
  modport master (
    input  i_SDRAM_Requested, i_Data_Read_Valid, i_Data_Write_Done,
    input  i_Rd_Ready, i_Wr_Ready, i_Restart,
    output o_SDRAM_Yield, o_Command, o_Data_Address, o_Rd_Wrreq,
    output o_Wr_Rdreq, o_Wr_Sel, o_Wrap
  );

  // Controller / FIFO side
  modport slave (
    output i_SDRAM_Requested, i_Data_Read_Valid, i_Data_Write_Done,
    output i_Rd_Ready, i_Wr_Ready, i_Restart,
    input  o_SDRAM_Yield, o_Command, o_Data_Address, o_Rd_Wrreq,
    input  o_Wr_Rdreq, o_Wr_Sel, o_Wrap
  );
endinterface

`default_nettype wire

// File: rtl/sdram_burst_streamer.sv
// ============================================================================
// Module      : sdram_burst_streamer
// Description : Multi-channel SDRAM burst sequencer. Each channel reads one
//               burst from its linear region into its readout FIFO, then
//               writes the same burst back in place from its writeback FIFO.
//               Channels are served round-robin; the bus is yielded to the
//               scan-out requester whenever the sequencer is idle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdram_burst_streamer #(
  parameter int                   NUM_CH   = 2,
  parameter int                   CH_W     = 3,
  parameter logic [NUM_CH*22-1:0] CH_BASE  = {22'h20000, 22'h00000},
  parameter logic [NUM_CH*22-1:0] CH_WORDS = {22'd1536000, 22'd96000},
  parameter logic [NUM_CH*8-1:0]  CH_BURST = {8'd128, 8'd8}
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_n,
  sdram_burst_streamer_if.master bus
);

  // SDRAM controller command encoding
  localparam logic [1:0] c_CMD_IDLE  = 2'd0;
  localparam logic [1:0] c_CMD_READ  = 2'd1;
  localparam logic [1:0] c_CMD_WRITE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  if (NUM_CH < 1 || NUM_CH > 8) begin : g_err_num_ch
    $fatal(1, "sdram_burst_streamer: NUM_CH must be 1..8");
  end
  if (CH_W < 1 || (1 << CH_W) < NUM_CH) begin : g_err_ch_w
    $fatal(1, "sdram_burst_streamer: CH_W too narrow for NUM_CH");
  end

  // Per-channel constants unpacked from the packed parameter vectors
  logic [21:0] w_base  [NUM_CH];
  logic [21:0] w_end   [NUM_CH];
  logic [7:0]  w_burst [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    if (CH_BURST[g*8 +: 8] == 8'd0) begin : g_err_burst
      $fatal(1, "sdram_burst_streamer: burst length must be 1..255");
    end
    if (CH_WORDS[g*22 +: 22] == 22'd0 ||
        (CH_WORDS[g*22 +: 22] % {14'd0, CH_BURST[g*8 +: 8]}) != 22'd0) begin : g_err_words
      $fatal(1, "sdram_burst_streamer: region length must be a nonzero multiple of burst");
    end
    assign w_base[g]  = CH_BASE[g*22 +: 22];
    assign w_burst[g] = CH_BURST[g*8 +: 8];
    assign w_end[g]   = CH_BASE[g*22 +: 22] + CH_WORDS[g*22 +: 22];
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t            r_state;
  state_t            w_state_nxt;
  logic [CH_W-1:0]   r_act;
  logic [CH_W-1:0]   r_rr_last;
  logic [21:0]       r_addr;
  logic [7:0]        r_cnt;
  logic [21:0]       r_ptr [NUM_CH];
  logic [NUM_CH-1:0] r_pend;
  logic [NUM_CH-1:0] r_wrap;

  logic [NUM_CH-1:0] w_wr_elig;
  logic [NUM_CH-1:0] w_rd_elig;
  logic              w_grant_valid;
  logic              w_grant_wr;
  logic [CH_W-1:0]   w_grant_ch;
  logic [21:0]       w_grant_addr;
  logic [7:0]        w_grant_cnt;
  logic              w_grant_take;
  logic              w_restart_take;

  logic [21:0]       w_act_ptr;
  logic [21:0]       w_act_end;
  logic [7:0]        w_act_burst;
  logic [21:0]       w_ptr_adv;
  logic              w_wraps;
  logic              w_beat;
  logic              w_last;

  // A channel alternates: write-back once its read burst is pending, else read
  assign w_wr_elig = r_pend & bus.i_Wr_Ready;
  assign w_rd_elig = ~r_pend & bus.i_Rd_Ready;

  // Round-robin scan starting just after the last served channel
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_wr    = 1'b0;
    w_grant_ch    = '0;
    w_grant_addr  = '0;
    w_grant_cnt   = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (!w_grant_valid && (c == ((int'(r_rr_last) + k) % NUM_CH)) &&
            (w_wr_elig[c] || w_rd_elig[c])) begin
          w_grant_valid = 1'b1;
          w_grant_wr    = w_wr_elig[c];
          w_grant_ch    = CH_W'(c);
          w_grant_addr  = r_ptr[c];
          w_grant_cnt   = w_burst[c] - 8'd1;
        end
      end
    end
  end

  // Restart only acts in IDLE; a grant needs the bus unrequested and no restart
  assign w_restart_take = (r_state == S_IDLE) && bus.i_Restart;
  assign w_grant_take   = (r_state == S_IDLE) && !bus.i_SDRAM_Requested &&
                          !bus.i_Restart && w_grant_valid;

  // Region bookkeeping values for the channel currently holding the bus
  always_comb begin
    w_act_ptr   = '0;
    w_act_end   = '0;
    w_act_burst = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (r_act == CH_W'(c)) begin
        w_act_ptr   = r_ptr[c];
        w_act_end   = w_end[c];
        w_act_burst = w_burst[c];
      end
    end
  end

  assign w_ptr_adv = w_act_ptr + {14'd0, w_act_burst};
  assign w_wraps   = (w_ptr_adv == w_act_end);
  assign w_beat    = ((r_state == S_READ)  && bus.i_Data_Read_Valid) ||
                     ((r_state == S_WRITE) && bus.i_Data_Write_Done);
  assign w_last    = w_beat && (r_cnt == 8'd0);

  // State register
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state plus the combinational command and per-beat FIFO strobes
  always_comb begin
    w_state_nxt           = r_state;
    bus.o_Command         = c_CMD_IDLE;
    bus.o_Rd_Wrreq        = '0;
    bus.o_Wr_Rdreq        = '0;
    bus.o_Wr_Sel          = '0;
    bus.o_SDRAM_Yield     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        bus.o_SDRAM_Yield = bus.i_SDRAM_Requested;
        if (w_grant_take) w_state_nxt = w_grant_wr ? S_WRITE : S_READ;
      end
      S_READ: begin
        bus.o_Command = c_CMD_READ;
        for (int c = 0; c < NUM_CH; c++) begin
          bus.o_Rd_Wrreq[c] = bus.i_Data_Read_Valid && (r_act == CH_W'(c));
        end
        if (w_last) w_state_nxt = S_IDLE;
      end
      S_WRITE: begin
        bus.o_Command  = c_CMD_WRITE;
        bus.o_Wr_Sel   = r_act;
        for (int c = 0; c < NUM_CH; c++) begin
          bus.o_Wr_Rdreq[c] = bus.i_Data_Write_Done && (r_act == CH_W'(c));
        end
        if (w_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Burst address/counter: load on grant, step on every accepted beat
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_act     <= '0;
      r_rr_last <= CH_W'(NUM_CH - 1);
      r_addr    <= '0;
      r_cnt     <= '0;
    end else if (w_grant_take) begin
      r_act     <= w_grant_ch;
      r_rr_last <= w_grant_ch;
      r_addr    <= w_grant_addr;
      r_cnt     <= w_grant_cnt;
    end else if (w_beat) begin
      r_addr    <= r_addr + 22'd1;
      r_cnt     <= r_cnt - 8'd1;
    end
  end

  // Per-channel region pointer, pending-writeback flag and wrap pulse
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      for (int c = 0; c < NUM_CH; c++) r_ptr[c] <= w_base[c];
      r_pend <= '0;
      r_wrap <= '0;
    end else begin
      r_wrap <= '0;
      if (w_restart_take) begin
        for (int c = 0; c < NUM_CH; c++) r_ptr[c] <= w_base[c];
        r_pend <= '0;
      end else if (w_last) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (r_act == CH_W'(c)) begin
            if (r_state == S_READ) begin
              r_pend[c] <= 1'b1;
            end else begin
              // Write-back completes the burst; advance or rewind the region
              r_pend[c] <= 1'b0;
              if (w_wraps) begin
                r_ptr[c]  <= w_base[c];
                r_wrap[c] <= 1'b1;
              end else begin
                r_ptr[c]  <= w_ptr_adv;
              end
            end
          end
        end
      end
    end
  end

  assign bus.o_Data_Address = r_addr;
  assign bus.o_Wrap         = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_sdram_burst_streamer.sv
// ============================================================================
// Module      : tb_sdram_burst_streamer
// Description : Self-checking bench for sdram_burst_streamer: directed vector
//               table, hand-written corner sequences and a randomized run
//               against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sdram_burst_streamer;

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_RD   = 2'd1;
  localparam logic [1:0] C_WR   = 2'd2;

  typedef struct {
    logic        req, valid, done, restart;
    logic [1:0]  rdr, wrr;
    logic [1:0]  cmd;
    logic [21:0] addr;
    logic [1:0]  rdw, wrq, wrap;
    logic [2:0]  sel;
    logic        yld;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  sdram_burst_streamer_if #(.NUM_CH(2), .CH_W(3)) bus ();

  sdram_burst_streamer #(
    .NUM_CH  (2),
    .CH_W    (3),
    .CH_BASE ({22'h20000, 22'h00000}),
    .CH_WORDS({22'd256, 22'd16}),
    .CH_BURST({8'd128, 8'd8})
  ) dut (
    .i_Clk  (clk),
    .i_Rst_n(rst_n),
    .bus    (bus.master)
  );

  function automatic vec_t mk(input logic req, valid, done, restart,
                              input logic [1:0] rdr, wrr, cmd,
                              input logic [21:0] addr,
                              input logic [1:0] rdw, wrq,
                              input logic [2:0] sel,
                              input logic [1:0] wrap,
                              input logic yld);
    vec_t v;
    v.req = req; v.valid = valid; v.done = done; v.restart = restart;
    v.rdr = rdr; v.wrr = wrr; v.cmd = cmd; v.addr = addr;
    v.rdw = rdw; v.wrq = wrq; v.sel = sel; v.wrap = wrap; v.yld = yld;
    return v;
  endfunction

  // Apply one cycle of inputs, compare outputs mid-cycle, advance past the edge
  task automatic cyc(input string nm, input vec_t v);
    logic [33:0] got, want;
    bus.i_SDRAM_Requested = v.req;
    bus.i_Data_Read_Valid = v.valid;
    bus.i_Data_Write_Done = v.done;
    bus.i_Restart         = v.restart;
    bus.i_Rd_Ready        = v.rdr;
    bus.i_Wr_Ready        = v.wrr;
    @(negedge clk);
    got  = {bus.o_Command, bus.o_Data_Address, bus.o_Rd_Wrreq, bus.o_Wr_Rdreq,
            bus.o_Wr_Sel, bus.o_Wrap, bus.o_SDRAM_Yield};
    want = {v.cmd, v.addr, v.rdw, v.wrq, v.sel, v.wrap, v.yld};
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s @%0t: got cmd=%0d addr=%h rdw=%b wrq=%b sel=%0d wrap=%b yld=%b, want cmd=%0d addr=%h rdw=%b wrq=%b sel=%0d wrap=%b yld=%b",
                  nm, $time, bus.o_Command, bus.o_Data_Address, bus.o_Rd_Wrreq,
                  bus.o_Wr_Rdreq, bus.o_Wr_Sel, bus.o_Wrap, bus.o_SDRAM_Yield,
                  v.cmd, v.addr, v.rdw, v.wrq, v.sel, v.wrap, v.yld);
    @(posedge clk);
    #1;
  endtask

  // ---------------- transaction-level reference model ----------------------
  int          m_base [2] = '{32'h0, 32'h20000};
  int          m_words[2] = '{16, 256};
  int          m_burst[2] = '{8, 128};
  bit          m_busy, m_is_wr;
  int          m_ch, m_last, m_left;
  logic [21:0] m_addr;
  logic [21:0] m_ptr [2];
  bit          m_pend[2];
  logic [1:0]  m_wrap;

  task automatic model_reset();
    m_busy = 0; m_is_wr = 0; m_ch = 0; m_last = 1; m_left = 0;
    m_addr = '0; m_wrap = '0;
    for (int c = 0; c < 2; c++) begin
      m_ptr[c]  = 22'(m_base[c]);
      m_pend[c] = 0;
    end
  endtask

  function automatic vec_t model_expect(input vec_t in);
    vec_t v = in;
    v.cmd  = !m_busy ? C_IDLE : (m_is_wr ? C_WR : C_RD);
    v.addr = m_addr;
    v.rdw  = (m_busy && !m_is_wr && in.valid) ? 2'(1 << m_ch) : 2'b00;
    v.wrq  = (m_busy &&  m_is_wr && in.done)  ? 2'(1 << m_ch) : 2'b00;
    v.sel  = (m_busy && m_is_wr) ? 3'(m_ch) : 3'd0;
    v.wrap = m_wrap;
    v.yld  = in.req && !m_busy;
    return v;
  endfunction

  task automatic model_step(input vec_t in);
    m_wrap = '0;
    if (!m_busy) begin
      if (in.restart) begin
        for (int c = 0; c < 2; c++) begin
          m_ptr[c]  = 22'(m_base[c]);
          m_pend[c] = 0;
        end
      end else if (!in.req) begin
        for (int k = 1; k <= 2 && !m_busy; k++) begin
          int c = (m_last + k) % 2;
          bit wr = m_pend[c] && in.wrr[c];
          bit rd = !m_pend[c] && in.rdr[c];
          if (wr || rd) begin
            m_busy = 1; m_is_wr = wr; m_ch = c; m_last = c;
            m_addr = m_ptr[c]; m_left = m_burst[c];
          end
        end
      end
    end else if ((!m_is_wr && in.valid) || (m_is_wr && in.done)) begin
      m_addr = m_addr + 22'd1;
      m_left--;
      if (m_left == 0) begin
        m_busy = 0;
        if (!m_is_wr) begin
          m_pend[m_ch] = 1;
        end else begin
          m_pend[m_ch] = 0;
          if (int'(m_ptr[m_ch]) + m_burst[m_ch] == m_base[m_ch] + m_words[m_ch]) begin
            m_ptr[m_ch]  = 22'(m_base[m_ch]);
            m_wrap[m_ch] = 1'b1;
          end else begin
            m_ptr[m_ch] = m_ptr[m_ch] + 22'(m_burst[m_ch]);
          end
        end
      end
    end
  endtask

  vec_t tbl[13];

  initial begin
    // Directed start-up vectors: first ch0 read with a stall, then yield, then ch1
    tbl[0]  = mk(0,0,0,0, 2'b11,2'b00, C_IDLE, 22'h0, 2'b00,2'b00,3'd0,2'b00,0);
    tbl[1]  = mk(0,1,0,0, 2'b11,2'b00, C_RD,   22'h0, 2'b01,2'b00,3'd0,2'b00,0);
    tbl[2]  = mk(0,0,0,0, 2'b11,2'b00, C_RD,   22'h1, 2'b00,2'b00,3'd0,2'b00,0);
    for (int i = 3; i <= 9; i++)
      tbl[i] = mk(0,1,0,0, 2'b11,2'b00, C_RD, 22'(i-2), 2'b01,2'b00,3'd0,2'b00,0);
    tbl[10] = mk(1,0,0,0, 2'b11,2'b00, C_IDLE, 22'h8, 2'b00,2'b00,3'd0,2'b00,1);
    tbl[11] = mk(0,0,0,0, 2'b11,2'b00, C_IDLE, 22'h8, 2'b00,2'b00,3'd0,2'b00,0);
    tbl[12] = mk(0,1,0,0, 2'b11,2'b00, C_RD,   22'h20000, 2'b10,2'b00,3'd0,2'b00,0);

    // Reset held with strobes toggling: every output quiet
    rst_n = 1'b0;
    #1;
    cyc("reset_a", mk(0,1,1,1, 2'b11,2'b11, C_IDLE, 22'h0, 2'b00,2'b00,3'd0,2'b00,0));
    cyc("reset_b", mk(0,0,1,0, 2'b01,2'b10, C_IDLE, 22'h0, 2'b00,2'b00,3'd0,2'b00,0));
    cyc("reset_c", mk(0,1,0,1, 2'b10,2'b01, C_IDLE, 22'h0, 2'b00,2'b00,3'd0,2'b00,0));
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) cyc($sformatf("table_%0d", i), tbl[i]);

    // Remainder of ch1 128-beat read
    for (int i = 1; i < 128; i++)
      cyc("ch1_read", mk(0,1,0,0, 2'b11,2'b00, C_RD, 22'h20000 + 22'(i), 2'b10,2'b00,3'd0,2'b00,0));

    // ch0 write-back at 0x0 (read-valid asserted too, must be ignored)
    cyc("grant_wr0", mk(0,0,0,0, 2'b00,2'b01, C_IDLE, 22'h20080, 2'b00,2'b00,3'd0,2'b00,0));
    for (int i = 0; i < 8; i++)
      cyc("ch0_write", mk(0,1,1,0, 2'b00,2'b01, C_WR, 22'(i), 2'b00,2'b01,3'd0,2'b00,0));
    cyc("no_wrap", mk(0,0,0,0, 2'b01,2'b00, C_IDLE, 22'h8, 2'b00,2'b00,3'd0,2'b00,0));
    for (int i = 0; i < 8; i++)
      cyc("ch0_read2", mk(0,1,0,0, 2'b01,2'b00, C_RD, 22'h8 + 22'(i), 2'b01,2'b00,3'd0,2'b00,0));
    cyc("grant_wr0b", mk(0,0,0,0, 2'b00,2'b01, C_IDLE, 22'h10, 2'b00,2'b00,3'd0,2'b00,0));
    for (int i = 0; i < 8; i++)
      cyc("ch0_write2", mk(0,0,1,0, 2'b00,2'b01, C_WR, 22'h8 + 22'(i), 2'b00,2'b01,3'd0,2'b00,0));
    cyc("wrap_pulse", mk(0,0,0,0, 2'b01,2'b00, C_IDLE, 22'h10, 2'b00,2'b00,3'd0,2'b01,0));

    // Request arrives mid-burst: burst finishes, then yield until released
    for (int i = 0; i < 8; i++)
      cyc("rd_after_wrap", mk(1,1,0,0, 2'b01,2'b00, C_RD, 22'(i), 2'b01,2'b00,3'd0,2'b00,0));
    for (int i = 0; i < 3; i++)
      cyc("yield", mk(1,0,0,0, 2'b11,2'b11, C_IDLE, 22'h8, 2'b00,2'b00,3'd0,2'b00,1));
    cyc("release", mk(0,0,0,0, 2'b00,2'b11, C_IDLE, 22'h8, 2'b00,2'b00,3'd0,2'b00,0));
    // ch1 write-back; restart asserted throughout and must be ignored
    for (int i = 0; i < 128; i++)
      cyc("ch1_write", mk(0,1,1,1, 2'b11,2'b11, C_WR, 22'h20000 + 22'(i), 2'b00,2'b10,3'd1,2'b00,0));

    // Restart in IDLE: no grant that cycle, pointers rewound, pend cleared
    cyc("restart", mk(0,0,0,1, 2'b11,2'b11, C_IDLE, 22'h20080, 2'b00,2'b00,3'd0,2'b00,0));
    cyc("pend_clr", mk(0,0,0,0, 2'b00,2'b01, C_IDLE, 22'h20080, 2'b00,2'b00,3'd0,2'b00,0));
    cyc("grant_rd1", mk(0,0,0,0, 2'b10,2'b11, C_IDLE, 22'h20080, 2'b00,2'b00,3'd0,2'b00,0));
    cyc("rewound_0", mk(0,1,0,0, 2'b10,2'b11, C_RD, 22'h20000, 2'b10,2'b00,3'd0,2'b00,0));
    cyc("rewound_1", mk(0,1,0,0, 2'b10,2'b11, C_RD, 22'h20001, 2'b10,2'b00,3'd0,2'b00,0));

    // Reset mid-read aborts the burst; afterwards ch0 is first
    rst_n = 1'b0;
    cyc("mid_rst_a", mk(0,1,1,0, 2'b11,2'b11, C_IDLE, 22'h0, 2'b00,2'b00,3'd0,2'b00,0));
    cyc("mid_rst_b", mk(0,1,1,0, 2'b11,2'b11, C_IDLE, 22'h0, 2'b00,2'b00,3'd0,2'b00,0));
    rst_n = 1'b1;
    cyc("post_rst_g", mk(0,0,0,0, 2'b11,2'b00, C_IDLE, 22'h0, 2'b00,2'b00,3'd0,2'b00,0));
    cyc("post_rst_r", mk(0,1,0,0, 2'b11,2'b00, C_RD, 22'h0, 2'b01,2'b00,3'd0,2'b00,0));

    // Randomized run against the reference model
    rst_n = 1'b0;
    cyc("rand_rst", mk(0,0,0,0, 2'b00,2'b00, C_IDLE, 22'h0, 2'b00,2'b00,3'd0,2'b00,0));
    rst_n = 1'b1;
    model_reset();
    for (int n = 0; n < 4000; n++) begin
      vec_t in;
      in = mk(($urandom % 8) == 0, ($urandom % 4) != 0, ($urandom % 4) != 0,
              ($urandom % 40) == 0, 2'($urandom), 2'($urandom),
              C_IDLE, 22'h0, 2'b00, 2'b00, 3'd0, 2'b00, 0);
      cyc("random", model_expect(in));
      model_step(in);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
